regfile_alu: RTL

REGFILE_ALU -- requirements
Module: regfile_alu

---
 rtl/regfile_alu.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/regfile_alu.sv
// Purpose: 16 x 16-bit register file feeding a two-operand ALU with registered result, flags, sticky error and write counter.
// Latency: one cycle from regEnable/ctrlA/ctrlB/inst to C, flags, err, wr_count and the register write.
// Backpressure: none; one request is accepted every cycle. Build option REGFILE_INIT_EN makes reset load R[i] = i.
module regfile_alu #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [15:0]        regEnable,
   input  logic [3:0]         ctrlA,
   input  logic [3:0]         ctrlB,
   input  logic [15:0]        inst,
   output logic [15:0]        C,
   output logic [4:0]         flags,
   output logic               err,
   output logic [COUNT_W-1:0] wr_count
);

   // Flag vector layout, MSB first: carry, low (unsigned A < B), overflow, zero, negative.
   typedef struct packed {
      logic c;
      logic l;
      logic f;
      logic z;
      logic n;
   } flags_t;

   localparam logic [3:0] OPX_AND = 4'b0001;
   localparam logic [3:0] OPX_OR  = 4'b0010;
   localparam logic [3:0] OPX_XOR = 4'b0011;
   localparam logic [3:0] OPX_ADD = 4'b0101;
   localparam logic [3:0] OPX_SUB = 4'b1001;
   localparam logic [3:0] OPX_CMP = 4'b1011;
   localparam logic [3:0] OPX_MOV = 4'b1101;

   logic [15:0]        regs_q [16];
   logic [15:0]        regs_d [16];
   logic [15:0]        c_q, c_d;
   flags_t             flags_q, flags_d;
   logic               err_q, err_d;
   logic [COUNT_W-1:0] wr_count_q, wr_count_d;

   logic [3:0]  opcode;
   logic [3:0]  opext;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [16:0] sum;
   logic [15:0] diff;
   logic [15:0] result;
   flags_t      res_flags;
   logic        op_legal;
   logic        is_write;
   logic        multi_hot;
   logic        req_legal;

   // Register-field bits outside opcode/opext carry no meaning for this datapath.
   logic unused_inst_bits;
   assign unused_inst_bits = ^{inst[11:8], inst[3:0]};

   // Decode the instruction, read both ports and compute the ALU result and its flags.
   always_comb begin
      opcode    = inst[15:12];
      opext     = inst[7:4];
      op_a      = regs_q[ctrlA];
      op_b      = regs_q[ctrlB];
      sum       = {1'b0, op_a} + {1'b0, op_b};
      diff      = op_a - op_b;
      result    = '0;
      res_flags = '0;
      op_legal  = 1'b1;
      is_write  = 1'b1;
      case (opext)
         OPX_ADD: begin
            result      = sum[15:0];
            res_flags.c = sum[16];
            res_flags.f = (op_a[15] == op_b[15]) && (result[15] != op_a[15]);
         end
         OPX_SUB, OPX_CMP: begin
            result      = diff;
            res_flags.c = (op_a < op_b);
            res_flags.l = (op_a < op_b);
            res_flags.f = (op_a[15] != op_b[15]) && (result[15] != op_a[15]);
            is_write    = (opext != OPX_CMP);
         end
         OPX_AND: result = op_a & op_b;
         OPX_OR:  result = op_a | op_b;
         OPX_XOR: result = op_a ^ op_b;
         OPX_MOV: result = op_b;
         default: op_legal = 1'b0;
      endcase
      if (opcode != 4'b0000) begin
         op_legal = 1'b0;
      end
      res_flags.z = (result == 16'h0000);
      res_flags.n = result[15];
      // More than one enable bit set means the destination is ambiguous.
      multi_hot = ((regEnable & (regEnable - 16'd1)) != 16'h0000);
      req_legal = op_legal && !multi_hot;
   end

   // Next-state: commit result/flags and at most one register write for legal requests, else latch err.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         regs_d[i] = regs_q[i];
      end
      c_d        = c_q;
      flags_d    = flags_q;
      err_d      = err_q;
      wr_count_d = wr_count_q;
      if (req_legal) begin
         c_d     = result;
         flags_d = res_flags;
         if (is_write && (regEnable != 16'h0000)) begin
            for (int i = 0; i < 16; i++) begin
               if (regEnable[i]) begin
                  regs_d[i] = result;
               end
            end
            if (wr_count_q != {COUNT_W{1'b1}}) begin
               wr_count_d = wr_count_q + COUNT_W'(1);
            end
         end
      end else begin
         err_d = 1'b1;
      end
   end

   // State registers; reset overrides any request presented on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
`ifdef REGFILE_INIT_EN
            regs_q[i] <= 16'(i);
`else
            regs_q[i] <= 16'h0000;
`endif
         end
         c_q        <= '0;
         flags_q    <= '0;
         err_q      <= 1'b0;
         wr_count_q <= '0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= regs_d[i];
         end
         c_q        <= c_d;
         flags_q    <= flags_d;
         err_q      <= err_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign C        = c_q;
   assign flags    = flags_q;
   assign err      = err_q;
   assign wr_count = wr_count_q;

endmodule
